// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state encoding, the owner index width and a clog2 helper.
package bus_arb_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit scanning from ptr upward.
// Ports: req_i, ptr_i in; win_o (one-hot), idx_o, any_o out.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int k;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        win_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and tenure sequencer for the shared system bus.
// Ports: clk, clr, DMA, BUS_ready in; grant, BUS_req, owner, owner_valid,
// bus_err, err_owner out.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = 8,
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N_MASTERS-1:0] DMA,
  input  logic                 BUS_ready,
  output logic [N_MASTERS-1:0] grant,
  output logic                 BUS_req,
  output logic [IDX_W-1:0]     owner,
  output logic                 owner_valid,
  output logic                 bus_err,
  output logic [IDX_W-1:0]     err_owner
);

  localparam int BW_RAW = clog2(MAX_BEATS + 1);
  localparam int WW_RAW = clog2(TIMEOUT + 1);
  localparam int BW = (BW_RAW < 1) ? 1 : BW_RAW;
  localparam int WW = (WW_RAW < 1) ? 1 : WW_RAW;

  localparam logic [BW-1:0] BEAT_LAST =
    BW'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
  localparam logic [WW-1:0] WD_LAST =
    WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [WW-1:0]          wdog_q, wdog_d;
  logic                   err_q, err_d;
  logic [IDX_W-1:0]       err_owner_q, err_owner_d;

  logic [N_MASTERS-1:0]   pick_win;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic [N_MASTERS-1:0]   own_mask;
  logic                   own_req;
  logic                   others_req;

  rr_pick #(
    .N(N_MASTERS)
  ) u_pick (
    .req_i(DMA),
    .ptr_i(ptr_q),
    .win_o(pick_win),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // Mask instead of DMA[owner_q] so narrow N needs no index trimming.
  assign own_mask   = N_MASTERS'(1) << owner_q;
  assign own_req    = |(DMA & own_mask);
  assign others_req = |(DMA & ~own_mask);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    wdog_d      = wdog_q;
    err_d       = 1'b0;
    err_owner_d = err_owner_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          owner_d = pick_idx;
          beat_d  = '0;
          wdog_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (own_req) begin
          state_d = XFER;
        end else begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      XFER: begin
        if (BUS_ready) begin
          wdog_d = '0;
          if (!(&beat_q)) beat_d = beat_q + 1'b1;
        end else if (!(&wdog_q)) begin
          wdog_d = wdog_q + 1'b1;
        end
        if (!own_req) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (TIMEOUT != 0 && !BUS_ready &&
                     wdog_q == WD_LAST) begin
          grant_d     = '0;
          err_d       = 1'b1;
          err_owner_d = owner_q;
          state_d     = RELEASE;
        end else if (MAX_BEATS != 0 && BUS_ready &&
                     beat_q == BEAT_LAST && others_req) begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = '0;
        ptr_d   = (owner_q == IDX_W'(N_MASTERS - 1)) ?
                  '0 : owner_q + 1'b1;
        beat_d  = '0;
        wdog_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      beat_q      <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      err_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      err_owner_q <= err_owner_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign owner_valid = (state_q == GRANT) || (state_q == XFER);
  assign BUS_req     = (state_q == XFER) && own_req;
  assign bus_err     = err_q;
  assign err_owner   = err_owner_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (N=8, MAX_BEATS=4, TIMEOUT=8).
// One task per scenario, each checking its own expected values.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] DMA;
  logic       BUS_ready;
  logic [7:0] grant;
  logic       BUS_req;
  logic [2:0] owner;
  logic       owner_valid;
  logic       bus_err;
  logic [2:0] err_owner;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .N_MASTERS(8),
    .MAX_BEATS(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .clr(clr),
    .DMA(DMA),
    .BUS_ready(BUS_ready),
    .grant(grant),
    .BUS_req(BUS_req),
    .owner(owner),
    .owner_valid(owner_valid),
    .bus_err(bus_err),
    .err_owner(err_owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    DMA = '0;
    BUS_ready = 1'b0;
    #2;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    DMA = 8'hFF;
    BUS_ready = 1'b1;
    #3;
    tests++;
    if (grant !== 8'h00 || BUS_req !== 1'b0 || owner !== 3'd0 ||
        owner_valid !== 1'b0 || bus_err !== 1'b0 ||
        err_owner !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs: got g=%h rq=%b o=%0d ov=%b e=%b eo=%0d want all 0",
               grant, BUS_req, owner, owner_valid, bus_err, err_owner);
    end
    tick();
    tests++;
    if (grant !== 8'h00 || owner_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: got g=%h ov=%b want 00 0",
               grant, owner_valid);
    end
    clr = 1'b0;
    DMA = '0;
    BUS_ready = 1'b0;
  endtask

  task automatic test_single();
    DMA = 8'h02;
    tick();
    tests++;
    if (grant !== 8'h02 || owner !== 3'd1 || owner_valid !== 1'b1 ||
        BUS_req !== 1'b0) begin
      fails++;
      $display("FAIL single_grant: got g=%h o=%0d ov=%b rq=%b want 02 1 1 0",
               grant, owner, owner_valid, BUS_req);
    end
    tick();
    tests++;
    if (BUS_req !== 1'b1) begin
      fails++;
      $display("FAIL single_req: got %b want 1", BUS_req);
    end
    tick();
    BUS_ready = 1'b1;
    tick();
    BUS_ready = 1'b0;
    DMA = 8'h00;
    tick();
    tests++;
    if (grant !== 8'h00 || owner_valid !== 1'b0 || BUS_req !== 1'b0) begin
      fails++;
      $display("FAIL single_release: got g=%h ov=%b rq=%b want 00 0 0",
               grant, owner_valid, BUS_req);
    end
    tick();
    tick();
    tests++;
    if (grant !== 8'h00) begin
      fails++;
      $display("FAIL single_idle: got %h want 00", grant);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp [4];
    logic [7:0] g;
    exp = '{8'h01, 8'h02, 8'h01, 8'h02};
    do_reset();
    DMA = 8'h03;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 10 && grant == 8'h00; c++) tick();
      g = grant;
      tests++;
      if (g !== exp[i]) begin
        fails++;
        $display("FAIL fair_grant%0d: got %h want %h", i, g, exp[i]);
      end
      tick();
      BUS_ready = 1'b1;
      tick();
      BUS_ready = 1'b0;
      DMA = 8'h03 & ~g;
      tick();
      DMA = 8'h03;
    end
    DMA = 8'h00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_preempt();
    do_reset();
    DMA = 8'h05;
    tick();
    tests++;
    if (grant !== 8'h01) begin
      fails++;
      $display("FAIL pre_first: got %h want 01", grant);
    end
    tick();
    BUS_ready = 1'b1;
    for (int b = 0; b < 3; b++) tick();
    tests++;
    if (grant !== 8'h01 || BUS_req !== 1'b1) begin
      fails++;
      $display("FAIL pre_early: got g=%h rq=%b want 01 1", grant, BUS_req);
    end
    tick();
    BUS_ready = 1'b0;
    tests++;
    if (grant !== 8'h00 || owner_valid !== 1'b0) begin
      fails++;
      $display("FAIL pre_cut: got g=%h ov=%b want 00 0", grant, owner_valid);
    end
    tick();
    tick();
    tests++;
    if (grant !== 8'h04) begin
      fails++;
      $display("FAIL pre_next: got %h want 04", grant);
    end
    tick();
    BUS_ready = 1'b1;
    tick();
    BUS_ready = 1'b0;
    DMA = 8'h01;
    tick();
    tick();
    tick();
    tests++;
    if (grant !== 8'h01) begin
      fails++;
      $display("FAIL pre_back: got %h want 01", grant);
    end
    DMA = 8'h00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int early;
    early = 0;
    do_reset();
    DMA = 8'h08;
    tick();
    tests++;
    if (grant !== 8'h08 || owner !== 3'd3) begin
      fails++;
      $display("FAIL wd_grant: got g=%h o=%0d want 08 3", grant, owner);
    end
    tick();
    for (int c = 0; c < 7; c++) begin
      tick();
      if (bus_err !== 1'b0 || grant !== 8'h08) early++;
    end
    tests++;
    if (early != 0) begin
      fails++;
      $display("FAIL wd_early: got %0d bad cycles want 0", early);
    end
    tick();
    tests++;
    if (bus_err !== 1'b1 || err_owner !== 3'd3 || grant !== 8'h00) begin
      fails++;
      $display("FAIL wd_abort: got e=%b eo=%0d g=%h want 1 3 00",
               bus_err, err_owner, grant);
    end
    tick();
    tests++;
    if (bus_err !== 1'b0 || err_owner !== 3'd3) begin
      fails++;
      $display("FAIL wd_pulse: got e=%b eo=%0d want 0 3", bus_err, err_owner);
    end
    tick();
    tests++;
    if (grant !== 8'h08) begin
      fails++;
      $display("FAIL wd_regrant: got %h want 08", grant);
    end
    DMA = 8'h00;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    DMA = 8'h01;
    tick();
    tick();
    tests++;
    if (BUS_req !== 1'b1) begin
      fails++;
      $display("FAIL ar_req: got %b want 1", BUS_req);
    end
    #2;
    clr = 1'b1;
    #1;
    tests++;
    if (grant !== 8'h00 || BUS_req !== 1'b0 || owner_valid !== 1'b0) begin
      fails++;
      $display("FAIL ar_drop: got g=%h rq=%b ov=%b want 00 0 0",
               grant, BUS_req, owner_valid);
    end
    #1;
    clr = 1'b0;
    DMA = 8'hFF;
    tick();
    tests++;
    if (grant !== 8'h01) begin
      fails++;
      $display("FAIL ar_prio: got %h want 01", grant);
    end
    DMA = 8'h00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_early_drop();
    do_reset();
    DMA = 8'h10;
    tick();
    tests++;
    if (grant !== 8'h10 || owner !== 3'd4) begin
      fails++;
      $display("FAIL ed_grant: got g=%h o=%0d want 10 4", grant, owner);
    end
    DMA = 8'h00;
    #1;
    tests++;
    if (BUS_req !== 1'b0) begin
      fails++;
      $display("FAIL ed_req_grant: got %b want 0", BUS_req);
    end
    tick();
    tests++;
    if (grant !== 8'h00 || owner_valid !== 1'b0 || BUS_req !== 1'b0) begin
      fails++;
      $display("FAIL ed_release: got g=%h ov=%b rq=%b want 00 0 0",
               grant, owner_valid, BUS_req);
    end
    tick();
    tests++;
    if (grant !== 8'h00 || BUS_req !== 1'b0) begin
      fails++;
      $display("FAIL ed_idle: got g=%h rq=%b want 00 0", grant, BUS_req);
    end
  endtask

  initial begin
    clr = 1'b0;
    DMA = '0;
    BUS_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_preempt();
    test_watchdog();
    test_async_reset();
    test_early_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
